// File: rtl/bloom_ctrl_if.sv
// bloom_ctrl_if: request/response and bit-array memory signals of bloom_ctrl.
// Signal suffixes are from the controller's point of view.
interface bloom_ctrl_if #(
  parameter int AW = 5
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [1:0]    op_i;
  logic [31:0]   data_i;
  logic          rsp_valid_o;
  logic          rsp_match_o;
  logic          rsp_err_o;
  logic          busy_o;
  logic [15:0]   count_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  modport slave (
    input  req_valid_i, op_i, data_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_match_o, rsp_err_o, busy_o, count_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output req_valid_i, op_i, data_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_match_o, rsp_err_o, busy_o, count_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/bloom_ctrl.sv
// bloom_ctrl: Bloom-filter insert/check/clear sequencer driving a single-port word-addressed bit array.
// Define BLOOM_AUTOCLR_EN to sweep the array automatically after reset (no response, not ready until done).
module bloom_ctrl #(
  parameter int NUM_HASH   = 3,
  parameter int ARRAY_BITS = 1024
) (
  input logic         clk_i,
  input logic         rst_ni,
  bloom_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ARRAY_BITS);
  localparam int WORDS = ARRAY_BITS / 32;
  localparam int AW    = $clog2(WORDS);
  typedef enum logic [2:0] {IDLE, RD, RDW, WR, CLR, RESP} state_t;
  state_t        state_q;
  logic          chk_q, req_q, we_q, rsp_q, match_q, err_q;
  logic [31:0]   data_q, wdata_q;
  logic [3:0]    i_q;
  logic [4:0]    bit_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   count_q;
`ifdef BLOOM_AUTOCLR_EN
  logic          auto_q;
`endif
  logic [31:0]      h_d, h_k, h_x, h_p;
  logic [IDX_W-1:0] idx_d;
  logic             last_d;
  // One shared hash unit: element from the bus at accept, otherwise the latched element at the next hash
  always_comb begin
    h_d    = state_q == IDLE ? bus.data_i : data_q;
    h_k    = state_q == IDLE ? 32'd0 : 32'(i_q) + 32'd1;
    h_x    = h_d ^ (h_d >> (32'd7 + 32'd4 * h_k));
    h_p    = h_x * (32'h9E3779B1 + h_k);
    idx_d  = h_p[31 -: IDX_W];
    last_d = i_q == 4'(NUM_HASH - 1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef BLOOM_AUTOCLR_EN
      state_q <= CLR;
      req_q   <= 1'b1;
      we_q    <= 1'b1;
      auto_q  <= 1'b1;
`else
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
`endif
      chk_q   <= 1'b0;
      rsp_q   <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
      i_q     <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      rsp_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          data_q  <= bus.data_i;
          chk_q   <= bus.op_i[0];
          i_q     <= '0;
          match_q <= 1'b0;
          err_q   <= 1'b0;
          case (bus.op_i)
            2'b10: begin
              state_q <= CLR;
              addr_q  <= '0;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              wdata_q <= '0;
            end
            2'b11: begin
              state_q <= RESP;
              rsp_q   <= 1'b1;
              err_q   <= 1'b1;
            end
            default: begin
              state_q <= RD;
              addr_q  <= idx_d[IDX_W-1:5];
              bit_q   <= idx_d[4:0];
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end
          endcase
        end
        RD: begin
          state_q <= RDW;
          req_q   <= 1'b0;
        end
        RDW: if (!chk_q) begin
          state_q <= WR;
          req_q   <= 1'b1;
          we_q    <= 1'b1;
          wdata_q <= bus.mem_rdata_i | (32'd1 << bit_q);
        end else if (!bus.mem_rdata_i[bit_q] || last_d) begin
          state_q <= RESP;
          rsp_q   <= 1'b1;
          match_q <= bus.mem_rdata_i[bit_q];
        end else begin
          state_q <= RD;
          i_q     <= i_q + 4'd1;
          addr_q  <= idx_d[IDX_W-1:5];
          bit_q   <= idx_d[4:0];
          req_q   <= 1'b1;
        end
        WR: begin
          we_q <= 1'b0;
          if (last_d) begin
            state_q <= RESP;
            rsp_q   <= 1'b1;
            req_q   <= 1'b0;
            count_q <= count_q + {15'd0, count_q != 16'hFFFF};
          end else begin
            state_q <= RD;
            i_q     <= i_q + 4'd1;
            addr_q  <= idx_d[IDX_W-1:5];
            bit_q   <= idx_d[4:0];
            req_q   <= 1'b1;
          end
        end
        CLR: if (addr_q == AW'(WORDS - 1)) begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          count_q <= '0;
`ifdef BLOOM_AUTOCLR_EN
          auto_q  <= 1'b0;
          state_q <= auto_q ? IDLE : RESP;
          rsp_q   <= ~auto_q;
`else
          state_q <= RESP;
          rsp_q   <= 1'b1;
`endif
        end else begin
          addr_q <= addr_q + AW'(1);
        end
        RESP: begin
          state_q <= IDLE;
          match_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready_o = state_q == IDLE;
  assign bus.busy_o      = state_q != IDLE;
  assign bus.rsp_valid_o = rsp_q;
  assign bus.rsp_match_o = match_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.count_o     = count_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_bloom_ctrl.sv
// tb_bloom_ctrl: table-driven operation vectors plus reset-abort and back-to-back sequences for bloom_ctrl.
module tb_bloom_ctrl;
  localparam int WORDS = 32;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic        exp_match;
    logic        exp_err;
    int          exp_lat;
    logic [15:0] exp_cnt;
    int          exp_rd;
    int          exp_wr;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] mem [WORDS];
  int nrd = 0, nwr = 0;
  int checks = 0, errors = 0;
  vec_t vecs [14];
  bloom_ctrl_if #(.AW(5)) bus ();
  bloom_ctrl #(.NUM_HASH(3), .ARRAY_BITS(1024)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        nwr <= nwr + 1;
      end else begin
        bus.mem_rdata_i <= mem[bus.mem_addr_o];
        nrd <= nrd + 1;
      end
    end
  end
  function automatic logic [9:0] ref_idx(input logic [31:0] d, input int k);
    logic [31:0] x, p;
    x = d ^ (d >> (7 + 4 * k));
    p = x * (32'h9E3779B1 + 32'(k));
    return p[31:22];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, output int lat,
                        output logic m, output logic e, output int rd, output int wr);
    int r0, w0, n;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.op_i = op;
    bus.data_i = d;
    r0 = nrd;
    w0 = nwr;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    chk("busy_after_accept", {31'd0, bus.req_ready_o}, 32'd0);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    m = bus.rsp_match_o;
    e = bus.rsp_err_o;
    @(posedge clk);
    #1;
    chk("rsp_one_cycle", {31'd0, bus.rsp_valid_o}, 32'd0);
    rd = nrd - r0;
    wr = nwr - w0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, rd, wr, n, bad;
    logic m, e, seen;
    logic [31:0] expw [WORDS];
    logic [1:0]  bop [4];
    logic [31:0] bdat [4];
    logic        bm [4];
    int          blat [4];
    vecs[0]  = '{2'b10, 32'h0,        1'b0, 1'b0, 33, 16'd0, 0, 32};
    vecs[1]  = '{2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 3,  16'd0, 1, 0};
    vecs[2]  = '{2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 10, 16'd1, 3, 3};
    vecs[3]  = '{2'b01, 32'hDEADBEEF, 1'b1, 1'b0, 7,  16'd1, 3, 0};
    vecs[4]  = '{2'b11, 32'h0,        1'b0, 1'b1, 1,  16'd1, 0, 0};
    for (int k = 0; k < 5; k++) vecs[5+k] = '{2'b00, 32'(k + 1), 1'b0, 1'b0, 10, 16'(k + 2), 3, 3};
    vecs[10] = '{2'b10, 32'h0,        1'b0, 1'b0, 33, 16'd0, 0, 32};
    vecs[11] = '{2'b01, 32'd3,        1'b0, 1'b0, 3,  16'd0, 1, 0};
    vecs[12] = '{2'b00, 32'd3,        1'b0, 1'b0, 10, 16'd1, 3, 3};
    vecs[13] = '{2'b01, 32'd3,        1'b1, 1'b0, 7,  16'd1, 3, 0};
    bus.req_valid_i = 1'b0;
    bus.op_i = 2'b00;
    bus.data_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_rsp", {29'd0, bus.rsp_valid_o, bus.rsp_match_o, bus.rsp_err_o}, 32'd0);
    chk("rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_count", {16'd0, bus.count_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      run_op(vecs[k].op, vecs[k].data, lat, m, e, rd, wr);
      chk($sformatf("v%0d_lat", k), 32'(lat), 32'(vecs[k].exp_lat));
      chk($sformatf("v%0d_match", k), {31'd0, m}, {31'd0, vecs[k].exp_match});
      chk($sformatf("v%0d_err", k), {31'd0, e}, {31'd0, vecs[k].exp_err});
      chk($sformatf("v%0d_count", k), {16'd0, bus.count_o}, {16'd0, vecs[k].exp_cnt});
      chk($sformatf("v%0d_reads", k), 32'(rd), 32'(vecs[k].exp_rd));
      chk($sformatf("v%0d_writes", k), 32'(wr), 32'(vecs[k].exp_wr));
    end
    for (int w = 0; w < WORDS; w++) expw[w] = '0;
    for (int k = 0; k < 3; k++) begin
      logic [9:0] ix;
      ix = ref_idx(32'd3, k);
      expw[ix[9:5]] = expw[ix[9:5]] | (32'd1 << ix[4:0]);
    end
    for (int w = 0; w < WORDS; w++) chk($sformatf("mem_word%0d", w), mem[w], expw[w]);
    // Abort an insert while it is writing
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.op_i = 2'b00;
    bus.data_i = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.mem_we_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_in_wr", {31'd0, bus.mem_we_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_memreq", {30'd0, bus.mem_req_o, bus.mem_we_o}, 32'd0);
    chk("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("abort_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("abort_count", {16'd0, bus.count_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      seen = seen | bus.rsp_valid_o | bus.mem_req_o;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);
    run_op(2'b11, 32'h0, lat, m, e, rd, wr);
    chk("post_abort_lat", 32'(lat), 32'd1);
    chk("post_abort_err", {31'd0, e}, 32'd1);
    chk("post_abort_mem", 32'(rd + wr), 32'd0);
    run_op(2'b10, 32'h0, lat, m, e, rd, wr);
    chk("clr_lat", 32'(lat), 32'd33);
    bad = 0;
    for (int w = 0; w < WORDS; w++) if (mem[w] !== 32'd0) bad++;
    chk("clr_zero_words", 32'(bad), 32'd0);
    chk("clr_count", {16'd0, bus.count_o}, 32'd0);
    // Back-to-back: request held high, alternating insert/check
    bop  = '{2'b00, 2'b01, 2'b00, 2'b01};
    bdat = '{32'hCAFE0001, 32'hCAFE0001, 32'h12345678, 32'h12345678};
    bm   = '{1'b0, 1'b1, 1'b0, 1'b1};
    blat = '{10, 7, 10, 7};
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.op_i = bop[0];
    bus.data_i = bdat[0];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.req_ready_o && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("b2b%0d_gap", k), 32'(n), k == 0 ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      lat = 1;
      bad = 0;
      while (!bus.rsp_valid_o && lat < 200) begin
        if (bus.req_ready_o) bad++;
        @(posedge clk);
        #1;
        lat++;
      end
      if (bus.req_ready_o) bad++;
      chk($sformatf("b2b%0d_lat", k), 32'(lat), 32'(blat[k]));
      chk($sformatf("b2b%0d_match", k), {31'd0, bus.rsp_match_o}, {31'd0, bm[k]});
      chk($sformatf("b2b%0d_ready_low", k), 32'(bad), 32'd0);
      chk($sformatf("b2b%0d_count", k), {16'd0, bus.count_o}, 32'(k / 2 + 1));
      if (k < 3) begin
        bus.op_i = bop[k+1];
        bus.data_i = bdat[k+1];
      end else begin
        bus.req_valid_i = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", {31'd0, bus.req_ready_o}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
